seq_led_pattern: RTL

- Parametrised successor to the fixed five-LED sequential blinker.
- Drives NUM_LEDS outputs with a runtime-selectable pattern: chase, bounce, fill or blink-all.
- Step rate comes from a programmable prescaler with a 4-level speed select; outputs have configurable polarity.
- Sits directly under the board top level, feeding LED pins.

---
 rtl/seq_led_pattern.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_led_pattern.sv
// Parametrised LED pattern sequencer: chase, bounce, fill or blink-all,
// stepped by a prescaler with 4-level speed select and optional active-low outputs.
module seq_led_pattern #(
  parameter int NUM_LEDS    = 5,
  parameter int STEP_CYCLES = 12500000,
  parameter bit ACTIVE_LOW  = 1'b0,
  localparam int POS_W      = $clog2(NUM_LEDS+1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic [1:0]          i_speed,
  output logic [NUM_LEDS-1:0] o_led,
  output logic                o_step,
  output logic [POS_W-1:0]    o_pos
);

  localparam int                  CNT_W = $clog2(STEP_CYCLES+1);
  localparam logic [CNT_W-1:0]    STEP  = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0]    CONE  = CNT_W'(1);
  localparam logic [POS_W-1:0]    ONE   = POS_W'(1);
  localparam logic [POS_W-1:0]    LAST  = POS_W'(NUM_LEDS-1);
  localparam logic [POS_W-1:0]    FULL  = POS_W'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] INV   = {NUM_LEDS{ACTIVE_LOW}};

  typedef enum logic [1:0] {CHASE = 2'd0, BOUNCE = 2'd1, FILL = 2'd2, BLINK = 2'd3} mode_e;

  logic [CNT_W-1:0]    cnt, lim_m1;
  logic                tick;
  mode_e               mode_r, m;
  logic [POS_W-1:0]    pos, p, pos_nxt;
  logic                dir, d, dir_nxt;   // 1 = counting up
  logic [NUM_LEDS-1:0] pat;

  // >= rather than == so lowering the limit below cnt ticks immediately
  always_comb begin
    lim_m1 = (STEP >> i_speed) - CONE;
    tick   = i_enable && (cnt >= lim_m1);
  end

  always_comb begin
    m       = mode_e'(i_mode);
    p       = (m != mode_r) ? '0 : pos;
    d       = (m != mode_r) ? 1'b1 : dir;
    pat     = '0;
    pos_nxt = '0;
    dir_nxt = 1'b1;
    case (m)
      CHASE: begin
        for (int i = 0; i < NUM_LEDS; i++) pat[i] = (POS_W'(i) == p);
        pos_nxt = (p == LAST) ? '0 : p + ONE;
      end
      BOUNCE: begin
        for (int i = 0; i < NUM_LEDS; i++) pat[i] = (POS_W'(i) == p);
        if (d) begin
          if (p == LAST) begin pos_nxt = LAST - ONE; dir_nxt = 1'b0; end
          else           begin pos_nxt = p + ONE;    dir_nxt = 1'b1; end
        end else begin
          if (p == '0)   begin pos_nxt = ONE;        dir_nxt = 1'b1; end
          else           begin pos_nxt = p - ONE;    dir_nxt = 1'b0; end
        end
      end
      FILL: begin
        for (int i = 0; i < NUM_LEDS; i++) pat[i] = (POS_W'(i) < p);
        pos_nxt = (p == FULL) ? '0 : p + ONE;
      end
      default: begin
        pat     = p[0] ? '0 : '1;
        pos_nxt = {{(POS_W-1){1'b0}}, ~p[0]};
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      pos    <= '0;
      dir    <= 1'b1;
      mode_r <= CHASE;
      o_led  <= INV;
      o_step <= 1'b0;
      o_pos  <= '0;
    end else begin
      if (i_enable) cnt <= tick ? '0 : cnt + CONE;
      if (tick) begin
        o_led  <= pat ^ INV;
        o_pos  <= p;
        o_step <= 1'b1;
        mode_r <= m;
        pos    <= pos_nxt;
        dir    <= dir_nxt;
      end else begin
        o_step <= 1'b0;
      end
    end
  end

endmodule
